// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - tile sequencer producing the 34-bit core instruction word; optional ACC phase under SEQ_ACC_EN
module core_sequencer #(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_nij  = 36,
  parameter int len_onij = 16,
  parameter int len_kij  = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_in,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam int CW = 16;
  localparam logic [CW-1:0] ONE = CW'(1);

`ifdef SEQ_ACC_EN
  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_X_L0, S_IF_WR, S_EXEC, S_OF_RD, S_ACC, S_DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_X_L0, S_IF_WR, S_EXEC, S_OF_RD, S_DONE
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // cycle index in timed phases, accepted reads in OF_RD, j in ACC
  logic [3:0]      kij_q, kij_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   rd_n;             // index of the read issued in the upcoming OF_RD cycle
  logic            rd_fire;
`ifdef SEQ_ACC_EN
  logic [CW-1:0]   o_q, o_d;
`endif
  logic [33:0]     inst_q, inst_d;
  logic            busy_q, busy_d, done_q, done_d;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      mode_q  <= 1'b0;
`ifdef SEQ_ACC_EN
      o_q     <= '0;
`endif
      inst_q  <= {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 9'd0, 1'b0, 1'b0, 7'd0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      mode_q  <= mode_d;
`ifdef SEQ_ACC_EN
      o_q     <= o_d;
`endif
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: phase lengths, kij stepping and OF_RD read acceptance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    kij_d   = kij_q;
    mode_d  = mode_q;
    rd_n    = '0;
    rd_fire = 1'b0;
`ifdef SEQ_ACC_EN
    o_d     = o_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_W_L0;
          kij_d   = '0;
          mode_d  = mode_in;
        end
      end
      S_W_L0:   if (cnt_q == CW'(col - 1))     begin state_d = S_W_LOAD; cnt_d = '0; end
      S_W_LOAD: if (cnt_q == CW'(col - 1))     begin state_d = S_GAP;    cnt_d = '0; end
      S_GAP:    if (cnt_q == CW'(9))           begin state_d = S_X_L0;   cnt_d = '0; end
      S_X_L0:   if (cnt_q == CW'(len_nij - 1)) begin state_d = S_IF_WR;  cnt_d = '0; end
      S_IF_WR:  if (cnt_q == CW'(len_nij - 1)) begin state_d = S_EXEC;   cnt_d = '0; end
      S_EXEC:   if (cnt_q == CW'(len_nij + col + row - 1)) begin state_d = S_OF_RD; cnt_d = '0; end
      S_OF_RD: begin
        cnt_d = cnt_q;
        if (cnt_q == CW'(len_onij)) begin
          cnt_d = '0;
          if (kij_q < 4'(len_kij - 1)) begin
            kij_d   = kij_q + 4'd1;
            state_d = S_W_L0;
          end else begin
`ifdef SEQ_ACC_EN
            state_d = S_ACC;
            o_d     = '0;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef SEQ_ACC_EN
      S_ACC: begin
        if (cnt_q == CW'(len_kij)) begin
          cnt_d = '0;
          if (o_q == CW'(len_onij - 1)) state_d = S_DONE;
          else                          o_d     = o_q + ONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A read is issued only when the OFIFO reports data; cnt then counts it
    if (state_d == S_OF_RD) begin
      rd_n = cnt_d;
      if (ofifo_valid) begin
        rd_fire = 1'b1;
        cnt_d   = cnt_d + ONE;
      end
    end
  end

  // Output decode for the upcoming cycle, registered by the state process
  always_comb begin
    logic        acc, cen_p, wen_p, cen_x, wen_x;
    logic [10:0] a_p, a_x;
    logic        of_rd, if_wr, if_rd, l0_rd, l0_wr, exe, ld;
    acc = 1'b0; cen_p = 1'b1; wen_p = 1'b1; cen_x = 1'b1; wen_x = 1'b1;
    a_p = '0; a_x = '0;
    of_rd = 1'b0; if_wr = 1'b0; if_rd = 1'b0; l0_rd = 1'b0; l0_wr = 1'b0; exe = 1'b0; ld = 1'b0;
    unique case (state_d)
      S_W_L0:   begin l0_wr = 1'b1; cen_x = 1'b0; a_x = 11'd1024 + cnt_d[10:0]; end
      S_W_LOAD: begin ld = 1'b1; l0_rd = 1'b1; end
      S_X_L0:   begin l0_wr = 1'b1; cen_x = 1'b0; a_x = cnt_d[10:0]; end
      S_IF_WR:  begin l0_rd = 1'b1; if_wr = 1'b1; end
      S_EXEC:   begin exe = 1'b1; if_rd = 1'b1; end
      S_OF_RD: begin
        if (rd_fire) begin
          of_rd = 1'b1;
          cen_p = 1'b0;
          wen_p = 1'b0;
          a_p   = 11'(32'(kij_d) * len_onij + 32'(rd_n));
        end
      end
`ifdef SEQ_ACC_EN
      S_ACC: begin
        acc = (cnt_d != '0);
        if (cnt_d < CW'(len_kij)) begin
          cen_p = 1'b0;
          a_p   = 11'(32'(cnt_d) * len_onij + 32'(o_d));
        end
      end
`endif
      default: ;
    endcase
    // A_xmem[1] is deliberately dropped from the word
    inst_d = {acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x[10:2], mode_d, a_x[0],
              of_rd, if_wr, if_rd, l0_rd, l0_wr, exe, ld};
    busy_d = !(state_d == S_IDLE || state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign kij  = kij_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer against a phase-level model
module tb_core_sequencer;
  localparam int COL = 8, ROW = 8, NIJ = 36, ONIJ = 16, KIJ = 9;
`ifdef SEQ_ACC_EN
  localparam int RUN_CYCLES = KIJ * (2 * COL + 10 + 2 * NIJ + (NIJ + COL + ROW) + ONIJ) + ONIJ * (KIJ + 1);
`else
  localparam int RUN_CYCLES = KIJ * (2 * COL + 10 + 2 * NIJ + (NIJ + COL + ROW) + ONIJ);
`endif

  logic        clk = 1'b0;
  logic        reset, start, mode_in, ofifo_valid;
  logic [33:0] inst;
  logic        busy, done;
  logic [3:0]  kij;

  int errs = 0;
  int checks = 0;
  int cycles = 0;
  bit first = 1'b0;

  core_sequencer #(.col(COL), .row(ROW), .len_nij(NIJ), .len_onij(ONIJ), .len_kij(KIJ)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij(kij)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction word from named fields; strobes = {ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load}
  function automatic logic [33:0] mk(input logic acc, input logic cenp, input logic wenp, input logic [10:0] ap,
                                     input logic cenx, input logic [10:0] ax, input logic m, input logic [6:0] strb);
    return {acc, cenp, wenp, ap, cenx, 1'b1, ax[10:2], m, ax[0], strb};
  endfunction

  function automatic logic [33:0] idle_word(input logic m);
    return mk(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, m, 7'd0);
  endfunction

  task automatic expect_out(input string tag, input logic [33:0] ei, input logic eb, input logic ed, input logic [3:0] ek);
    check({tag, ".inst"}, inst, ei);
    check({tag, ".busy"}, 34'(busy), 34'(eb));
    check({tag, ".done"}, 34'(done), 34'(ed));
    check({tag, ".kij"},  34'(kij),  34'(ek));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of an active run: start only on the first cycle, otherwise stray starts and mode toggles
  task automatic nxt(input logic v);
    ofifo_valid = v;
    if (first) begin
      start = 1'b1;
    end else begin
      start   = ($urandom_range(0, 31) == 0);
      mode_in = 1'($urandom_range(0, 1));
      cycles++;
    end
    first = 1'b0;
    tick();
  endtask

  function automatic logic rv(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic run_tile(input logic m, input bit rnd, input int abort_kij);
    logic v;
    int n, c;
    first   = 1'b1;
    cycles  = 0;
    mode_in = m;
    for (int k = 0; k < KIJ; k++) begin
      for (int t = 0; t < COL; t++) begin
        nxt(rv(rnd));
        expect_out("w_l0", mk(0, 1, 1, 0, 0, 11'(1024 + t), m, 7'b0000100), 1, 0, 4'(k));
      end
      for (int t = 0; t < COL; t++) begin
        nxt(rv(rnd));
        expect_out("w_load", mk(0, 1, 1, 0, 1, 0, m, 7'b0001001), 1, 0, 4'(k));
      end
      for (int t = 0; t < 10; t++) begin
        nxt(rv(rnd));
        expect_out("gap", idle_word(m), 1, 0, 4'(k));
      end
      for (int t = 0; t < NIJ; t++) begin
        nxt(rv(rnd));
        expect_out("x_l0", mk(0, 1, 1, 0, 0, 11'(t), m, 7'b0000100), 1, 0, 4'(k));
      end
      for (int t = 0; t < NIJ; t++) begin
        nxt(rv(rnd));
        expect_out("if_wr", mk(0, 1, 1, 0, 1, 0, m, 7'b0101000), 1, 0, 4'(k));
      end
      for (int t = 0; t < NIJ + COL + ROW; t++) begin
        if (k == abort_kij && t == 10) begin
          reset = 1'b1; start = 1'b1; ofifo_valid = 1'b1;
          tick();
          expect_out("abort_rst", idle_word(1'b0), 0, 0, 4'd0);
          reset = 1'b0; start = 1'b0;
          tick();
          expect_out("abort_idle", idle_word(1'b0), 0, 0, 4'd0);
          return;
        end
        nxt(rv(rnd));
        expect_out("exec", mk(0, 1, 1, 0, 1, 0, m, 7'b0010010), 1, 0, 4'(k));
      end
      n = 0;
      c = 0;
      while (n < ONIJ) begin
        if (!rnd || c >= 200) v = 1'b1;
        else if (k == 2)      v = (c % 2 == 0);
        else if (k == 5)      v = (c >= 20) && ($urandom_range(0, 2) != 0);
        else                  v = ($urandom_range(0, 2) != 0);
        nxt(v);
        if (v) expect_out("of_rd", mk(0, 0, 0, 11'(k * ONIJ + n), 1, 0, m, 7'b1000000), 1, 0, 4'(k));
        else   expect_out("of_stall", idle_word(m), 1, 0, 4'(k));
        if (v) n++;
        c++;
      end
    end
`ifdef SEQ_ACC_EN
    for (int o = 0; o < ONIJ; o++) begin
      for (int j = 0; j <= KIJ; j++) begin
        nxt(rv(rnd));
        if (j < KIJ) expect_out("acc", mk(1'(j >= 1), 0, 1, 11'(j * ONIJ + o), 1, 0, m, 7'd0), 1, 0, 4'(KIJ - 1));
        else         expect_out("acc_gap", mk(1, 1, 1, 0, 1, 0, m, 7'd0), 1, 0, 4'(KIJ - 1));
      end
    end
`endif
    nxt(rv(rnd));
    expect_out("done", idle_word(m), 0, 1, 4'(KIJ - 1));
    if (!rnd) check("run_cycles", 34'(cycles), 34'(RUN_CYCLES));
    nxt(rv(rnd));
    expect_out("post_done", idle_word(m), 0, 0, 4'(KIJ - 1));
    start = 1'b0;
    tick();
    expect_out("idle_hold", idle_word(m), 0, 0, 4'(KIJ - 1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; mode_in = 1'b1; ofifo_valid = 1'b1;
    repeat (3) tick();
    expect_out("reset", idle_word(1'b0), 0, 0, 4'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    expect_out("idle", idle_word(1'b0), 0, 0, 4'd0);
    run_tile(1'b1, 1'b1, -1);
    run_tile(1'b1, 1'b0, -1);
    run_tile(1'b0, 1'b1, 4);
    run_tile(1'($urandom_range(0, 1)), 1'b1, -1);
    run_tile(1'b0, 1'b0, -1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter col, default 8, PE array columns (number of weight rows loaded per kij).
REQ-002 SHALL have parameter row, default 8, PE array rows (pipeline drain length).
REQ-003 SHALL have parameter len_nij, default 36, activation vectors per tile.
REQ-004 SHALL have parameter len_onij, default 16, output pixels per kij.
REQ-005 SHALL have parameter len_kij, default 9, kernel positions per run.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1, one-cycle request to run one full tile.
REQ-009 SHALL have port mode_in, input, 1, sampled on accepted start: 0 selects 4-bit, 1 selects 2-bit SIMD.
REQ-010 SHALL have port ofifo_valid, input, 1, driven by core, meaning the OFIFO holds a readable row.
REQ-011 SHALL have port inst, output, 34, core instruction word: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:9] A_xmem[10:2], [8] mode, [7] A_xmem[0], [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE and DONE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on the cycle DONE is entered.
REQ-014 SHALL have port kij, output, 4, index of the current kernel position.

Function
REQ-015 SHALL register all outputs; inst fields change only on a rising clk edge.
REQ-016 SHALL implement states IDLE, W_L0, W_LOAD, GAP, X_L0, IF_WR, EXEC, OF_RD, [ACC], DONE.
REQ-017 SHALL treat a start sampled high in IDLE as accepted: W_L0 begins the next cycle, kij=0, and mode is latched. A start outside IDLE SHALL be ignored.
REQ-018 W_L0 SHALL last col cycles with l0_wr=1, CEN_xmem=0, WEN_xmem=1, and A_xmem=1024+t, where t=0..col-1.
REQ-019 W_LOAD SHALL last col cycles with load=1, l0_rd=1, and CEN_xmem=1.
REQ-020 GAP SHALL last 10 cycles with all strobes deasserted.
REQ-021 X_L0 SHALL last len_nij cycles with l0_wr=1, CEN_xmem=0, and A_xmem=t.
REQ-022 IF_WR SHALL last len_nij cycles with l0_rd=1 and ififo_wr=1.
REQ-023 EXEC SHALL last len_nij+col+row cycles with execute=1 and ififo_rd=1.
REQ-024 OF_RD SHALL assert ofifo_rd in a cycle only when ofifo_valid=1, and SHALL count only accepted reads.
REQ-025 For each accepted read n, OF_RD SHALL drive CEN_pmem=0, WEN_pmem=0, and A_pmem=kij*len_onij+n; the state exits after len_onij accepted reads.
REQ-026 If ofifo_valid stays low, OF_RD SHALL stall indefinitely with ofifo_rd=0 and CEN_pmem=1.
REQ-027 On OF_RD exit, if kij<len_kij-1 the sequencer SHALL increment kij and return to W_L0; otherwise it SHALL proceed to ACC (macro defined) or DONE.
REQ-028 DONE SHALL last one cycle and then return to IDLE; kij SHALL hold its last value until the next start.
REQ-029 Outside the states named above, CEN_xmem, WEN_xmem, CEN_pmem and WEN_pmem SHALL be 1, all other strobes 0, and addresses 0.
REQ-030 A_xmem[1] SHALL NOT appear on inst; address generation SHALL still produce a full 11-bit count.

Reset
REQ-031 reset=1 SHALL force IDLE from any state, including mid-phase, and clear every counter.
REQ-032 During reset, outputs SHALL be inst={acc=0, CEN_pmem=1, WEN_pmem=1, A_pmem=0, CEN_xmem=1, WEN_xmem=1, A_xmem=0, mode=0, all strobes 0}, busy=0, done=0, kij=0.
REQ-033 reset SHALL take priority over start in the same cycle.

Configuration
REQ-034 Macro SEQ_ACC_EN: when defined, the ACC state SHALL follow the last OF_RD.
REQ-035 ACC SHALL iterate o=0..len_onij-1, spending len_kij+1 cycles per o.
REQ-036 In ACC cycle j<len_kij, the sequencer SHALL drive CEN_pmem=0, WEN_pmem=1, and A_pmem=j*len_onij+o; in cycle j=len_kij, CEN_pmem=1.
REQ-037 In ACC, acc SHALL be 1 for j>=1 and 0 for j=0.
REQ-038 When SEQ_ACC_EN is undefined, ACC SHALL NOT exist, acc SHALL be tied to 0, and OF_RD on the last kij SHALL go directly to DONE.

Verification
REQ-039 Defaults, start with mode_in=1, ofifo_valid held 1 -> done 1494 cycles after start without SEQ_ACC_EN (1654 with); inst[8]=1 throughout.
REQ-040 Cycle-by-cycle trace of kij=0 -> A_xmem walks 1024..1031 in W_L0; load=1 for exactly 8 cycles; execute=1 for exactly 52 cycles.
REQ-041 OF_RD at kij=2 with ofifo_valid toggling 1,0,1,0 -> ofifo_rd mirrors ofifo_valid; A_pmem steps 32,33,...,47 only on accepted reads; 16 accepted reads, then W_L0.
REQ-042 reset pulsed for one cycle in EXEC of kij=4 -> next cycle is IDLE with the REQ-032 values; a fresh start restarts at kij=0.
REQ-043 start pulsed while busy, and start together with reset -> both ignored; state and counters unchanged.
REQ-044 With SEQ_ACC_EN, o=3 -> A_pmem sequence 3,19,35,...,131; acc=0,1,1,...,1; the tenth cycle has CEN_pmem=1 and acc=1.
